// File: rtl/bp_be_pkg.sv
// Shared types for the backend branch resolver.
//
// Contents:
//   `BP_BE_BR_RESOLVE_WIDTH(vaddr_width_mp)
//       Packed width of one resolve-stage entry.
//   `DECLARE_BP_BE_BR_RESOLVE_S(vaddr_width_mp)
//       Declares the bp_be_br_resolve_s struct in the calling scope. The
//       struct holds pc, npc_pred, tgt, taken and v.
//   bp_be_resolver_state_e
//       Redirect FSM states: e_idle and e_pend.
//   bp_be_tgt_misaligned()
//       Instruction-address alignment check on the low target bits.

`ifndef BP_BE_PKG_MACROS
`define BP_BE_PKG_MACROS

`define BP_BE_BR_RESOLVE_WIDTH(vaddr_width_mp) (3*(vaddr_width_mp)+2)

`define DECLARE_BP_BE_BR_RESOLVE_S(vaddr_width_mp) \
    typedef struct packed {                        \
        logic [(vaddr_width_mp)-1:0] pc;           \
        logic [(vaddr_width_mp)-1:0] npc_pred;     \
        logic [(vaddr_width_mp)-1:0] tgt;          \
        logic                        taken;        \
        logic                        v;            \
    } bp_be_br_resolve_s

`endif

package bp_be_pkg;

    typedef enum logic {
        e_idle = 1'b0,
        e_pend = 1'b1
    } bp_be_resolver_state_e;

    // Only 4-byte instructions exist here, so both low bits must be clear.
    function automatic logic bp_be_tgt_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/bp_be_sat_counter.sv
// Saturating up-counter.
//
// Ports:
//   clk_i    - clock
//   reset_i  - asynchronous active-high reset; clears the count
//   incr_i   - increment request; ignored once the count is all-ones
//   count_o  - current count

module bp_be_sat_counter #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               incr_i,
    output logic [width_p-1:0] count_o
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_o <= '0;
        end else if (incr_i && (count_o != '1)) begin
            count_o <= count_o + width_p'(1);
        end
    end

endmodule

// File: rtl/bp_be_br_resolver.sv
// Backend branch resolver. This block sits after the integer pipe.
//
// Each branch or jump is captured in one cycle and resolved in the next.
// On resolve, the actual next PC from the integer pipe is compared against
// the frontend's prediction. The possible outcomes are:
//   - an attaboy pulse on a correct prediction,
//   - a misalign pulse on a misaligned taken target,
//   - a one-cycle squash plus a redirect that is held until the frontend
//     accepts it, on a mispredict.
// Mispredicts are also counted with a saturating counter.
//
// Ports:
//   clk_i, reset_i         - clock, asynchronous active-high reset
//   v_i, br_v_i, jmp_v_i   - valid instruction, conditional branch, jal/jalr
//   pc_i, npc_pred_i       - instruction PC and predicted next PC
//   taken_i, br_tgt_i      - integer pipe taken flag and resolved next PC
//   flush_i                - commit-stage flush (highest priority after reset)
//   redirect_ready_i       - frontend can accept a redirect
//   redirect_v_o/pc_o      - held redirect to the frontend
//   squash_o               - one-cycle kill of younger instructions
//   attaboy_v_o/pc_o       - correct-prediction pulse
//   misalign_v_o/pc_o      - instruction-address-misaligned pulse
//   mispredict_cnt_o       - saturating mispredict count

module bp_be_br_resolver
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int cnt_width_p   = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic                     br_v_i,
    input  logic                     jmp_v_i,
    input  logic [vaddr_width_p-1:0] pc_i,
    input  logic [vaddr_width_p-1:0] npc_pred_i,
    input  logic                     taken_i,
    input  logic [vaddr_width_p-1:0] br_tgt_i,
    input  logic                     flush_i,
    input  logic                     redirect_ready_i,
    output logic                     redirect_v_o,
    output logic [vaddr_width_p-1:0] redirect_pc_o,
    output logic                     squash_o,
    output logic                     attaboy_v_o,
    output logic [vaddr_width_p-1:0] attaboy_pc_o,
    output logic                     misalign_v_o,
    output logic [vaddr_width_p-1:0] misalign_pc_o,
    output logic [cnt_width_p-1:0]   mispredict_cnt_o
);

    `DECLARE_BP_BE_BR_RESOLVE_S(vaddr_width_p);

    bp_be_br_resolve_s        resolve_r;
    bp_be_resolver_state_e    state_r;
    logic [vaddr_width_p-1:0] redirect_pc_r;

    logic block;
    logic capture;
    logic res_v;
    logic misalign;
    logic correct;
    logic mispredict;

    // While a redirect is pending, or in the squash cycle itself, anything
    // the integer pipe presents is on the wrong path.
    assign block   = (state_r == e_pend) | squash_o;
    assign capture = v_i & (br_v_i | jmp_v_i) & ~flush_i & ~block;

    // A flush in the resolve cycle discards the instruction being resolved.
    assign res_v      = resolve_r.v & ~flush_i;
    assign misalign   = res_v & resolve_r.taken & bp_be_tgt_misaligned(resolve_r.tgt[1:0]);
    assign correct    = res_v & ~misalign & (resolve_r.tgt == resolve_r.npc_pred);
    assign mispredict = res_v & ~misalign & (resolve_r.tgt != resolve_r.npc_pred);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            resolve_r <= '0;
        end else begin
            resolve_r.v <= capture;
            if (capture) begin
                resolve_r.pc       <= pc_i;
                resolve_r.npc_pred <= npc_pred_i;
                resolve_r.tgt      <= br_tgt_i;
                resolve_r.taken    <= taken_i;
            end
        end
    end

    // The redirect is raised combinationally in the mispredict cycle, which
    // is the same cycle as the squash. If the frontend accepts it right away,
    // the FSM never leaves IDLE. Otherwise PEND holds the request, and the
    // target is latched so that it stays stable.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r       <= e_idle;
            redirect_pc_r <= '0;
        end else begin
            if (mispredict) begin
                redirect_pc_r <= resolve_r.tgt;
            end
            case (state_r)
                e_idle: if (mispredict && !redirect_ready_i) state_r <= e_pend;
                e_pend: if (flush_i || redirect_ready_i)     state_r <= e_idle;
            endcase
        end
    end

    // A flush cancels a pending redirect in the same cycle. The commit stage
    // owns the redirect from then on.
    assign redirect_v_o  = ((state_r == e_pend) & ~flush_i) | mispredict;
    assign redirect_pc_o = mispredict ? resolve_r.tgt : redirect_pc_r;
    assign squash_o      = mispredict;
    assign attaboy_v_o   = correct;
    assign attaboy_pc_o  = resolve_r.pc;
    assign misalign_v_o  = misalign;
    assign misalign_pc_o = resolve_r.tgt;

    bp_be_sat_counter #(
        .width_p (cnt_width_p)
    ) mispredict_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .incr_i  (mispredict),
        .count_o (mispredict_cnt_o)
    );

endmodule

// File: tb/tb_bp_be_br_resolver.sv
// Bench for bp_be_br_resolver. It runs directed scenarios first and then
// randomized traffic against a transaction-level model. A small counter
// width is used so that saturation can be reached quickly.

module tb_bp_be_br_resolver;

    localparam int VW      = 39;
    localparam int CW      = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          v, br_v, jmp_v, taken, flush, ready;
    logic [VW-1:0] pc, npc_pred, br_tgt;
    logic          redirect_v, squash, attaboy_v, misalign_v;
    logic [VW-1:0] redirect_pc, attaboy_pc, misalign_pc;
    logic [CW-1:0] cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    bp_be_br_resolver #(
        .vaddr_width_p (VW),
        .cnt_width_p   (CW)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .v_i              (v),
        .br_v_i           (br_v),
        .jmp_v_i          (jmp_v),
        .pc_i             (pc),
        .npc_pred_i       (npc_pred),
        .taken_i          (taken),
        .br_tgt_i         (br_tgt),
        .flush_i          (flush),
        .redirect_ready_i (ready),
        .redirect_v_o     (redirect_v),
        .redirect_pc_o    (redirect_pc),
        .squash_o         (squash),
        .attaboy_v_o      (attaboy_v),
        .attaboy_pc_o     (attaboy_pc),
        .misalign_v_o     (misalign_v),
        .misalign_pc_o    (misalign_pc),
        .mispredict_cnt_o (cnt)
    );

    task automatic clear_inputs();
        v = 0; br_v = 0; jmp_v = 0; taken = 0; flush = 0;
        pc = '0; npc_pred = '0; br_tgt = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_branch(input logic is_jmp, input logic [VW-1:0] ipc,
                                input logic [VW-1:0] ipred, input logic [VW-1:0] itgt,
                                input logic itaken);
        v = 1; br_v = ~is_jmp; jmp_v = is_jmp;
        pc = ipc; npc_pred = ipred; br_tgt = itgt; taken = itaken;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (redirect_v !== 1'b0) begin errors++; $display("[TB] FAIL reset_redirect_v got %0b want 0", redirect_v); end
        checks++; if (squash !== 1'b0) begin errors++; $display("[TB] FAIL reset_squash got %0b want 0", squash); end
        checks++; if (attaboy_v !== 1'b0) begin errors++; $display("[TB] FAIL reset_attaboy got %0b want 0", attaboy_v); end
        checks++; if (misalign_v !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign got %0b want 0", misalign_v); end
        checks++; if (cnt !== '0) begin errors++; $display("[TB] FAIL reset_cnt got %0d want 0", cnt); end
        checks++; if (redirect_pc !== '0) begin errors++; $display("[TB] FAIL reset_redirect_pc got %0h want 0", redirect_pc); end
        next_cycle();
        reset = 0;
    endtask

    task automatic test_correct_branch();
        drive_branch(0, 'h1000, 'h1040, 'h1040, 1);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (attaboy_v !== 1'b1) begin errors++; $display("[TB] FAIL correct_attaboy_v got %0b want 1", attaboy_v); end
        checks++; if (attaboy_pc !== 39'h1000) begin errors++; $display("[TB] FAIL correct_attaboy_pc got %0h want 1000", attaboy_pc); end
        checks++; if (squash !== 1'b0) begin errors++; $display("[TB] FAIL correct_squash got %0b want 0", squash); end
        checks++; if (redirect_v !== 1'b0) begin errors++; $display("[TB] FAIL correct_redirect_v got %0b want 0", redirect_v); end
        next_cycle();
        @(negedge clk);
        checks++; if (attaboy_v !== 1'b0) begin errors++; $display("[TB] FAIL correct_attaboy_pulse got %0b want 0", attaboy_v); end
        checks++; if (cnt !== CW'(exp_cnt)) begin errors++; $display("[TB] FAIL correct_cnt got %0d want %0d", cnt, exp_cnt); end
    endtask

    task automatic test_mispredict_hold();
        ready = 0;
        drive_branch(0, 'h2000, 'h2100, 'h2004, 0);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (squash !== 1'b1) begin errors++; $display("[TB] FAIL hold_squash got %0b want 1", squash); end
        checks++; if (redirect_v !== 1'b1) begin errors++; $display("[TB] FAIL hold_redirect_rise got %0b want 1", redirect_v); end
        checks++; if (redirect_pc !== 39'h2004) begin errors++; $display("[TB] FAIL hold_redirect_pc0 got %0h want 2004", redirect_pc); end
        exp_cnt++;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            checks++; if (squash !== 1'b0) begin errors++; $display("[TB] FAIL hold_squash_once got %0b want 0", squash); end
            checks++; if (redirect_v !== 1'b1) begin errors++; $display("[TB] FAIL hold_redirect_v got %0b want 1", redirect_v); end
            checks++; if (redirect_pc !== 39'h2004) begin errors++; $display("[TB] FAIL hold_redirect_pc got %0h want 2004", redirect_pc); end
        end
        next_cycle();
        ready = 1;
        @(negedge clk);
        checks++; if (redirect_v !== 1'b1) begin errors++; $display("[TB] FAIL hold_accept_cycle got %0b want 1", redirect_v); end
        next_cycle();
        ready = 0;
        @(negedge clk);
        checks++; if (redirect_v !== 1'b0) begin errors++; $display("[TB] FAIL hold_drop got %0b want 0", redirect_v); end
        checks++; if (cnt !== CW'(exp_cnt)) begin errors++; $display("[TB] FAIL hold_cnt got %0d want %0d", cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        ready = 0;
        drive_branch(0, 'h5000, 'h5100, 'h5004, 0);
        next_cycle();
        drive_branch(0, 'h6000, 'h6100, 'h6004, 0);
        @(negedge clk);
        checks++; if (squash !== 1'b1) begin errors++; $display("[TB] FAIL b2b_squash got %0b want 1", squash); end
        exp_cnt++;
        next_cycle();
        drive_branch(1, 'h7000, 'h7100, 'h7200, 1);
        @(negedge clk);
        checks++; if (squash !== 1'b0) begin errors++; $display("[TB] FAIL b2b_squash_shadow got %0b want 0", squash); end
        checks++; if (redirect_pc !== 39'h5004) begin errors++; $display("[TB] FAIL b2b_pc_pend got %0h want 5004", redirect_pc); end
        next_cycle();
        clear_inputs();
        ready = 1;
        @(negedge clk);
        checks++; if (squash !== 1'b0) begin errors++; $display("[TB] FAIL b2b_squash_pend got %0b want 0", squash); end
        checks++; if (redirect_pc !== 39'h5004) begin errors++; $display("[TB] FAIL b2b_pc_accept got %0h want 5004", redirect_pc); end
        next_cycle();
        ready = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (redirect_v !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_second_redirect got %0b want 0", redirect_v); end
            checks++; if (squash !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_second_squash got %0b want 0", squash); end
            next_cycle();
        end
        checks++; if (cnt !== CW'(exp_cnt)) begin errors++; $display("[TB] FAIL b2b_cnt got %0d want %0d", cnt, exp_cnt); end
    endtask

    task automatic test_flush();
        ready = 0;
        drive_branch(0, 'h8000, 'h8100, 'h8004, 0);
        next_cycle();
        clear_inputs();
        exp_cnt++;
        next_cycle();
        flush = 1;
        next_cycle();
        flush = 0;
        @(negedge clk);
        checks++; if (redirect_v !== 1'b0) begin errors++; $display("[TB] FAIL flush_pend_drop got %0b want 0", redirect_v); end
        // Once back in IDLE, a new branch must be accepted again.
        next_cycle();
        drive_branch(0, 'hB000, 'hB004, 'hB004, 0);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (attaboy_v !== 1'b1) begin errors++; $display("[TB] FAIL flush_idle_attaboy got %0b want 1", attaboy_v); end
        next_cycle();
        drive_branch(0, 'h9000, 'h9100, 'h9004, 0);
        flush = 1;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (squash !== 1'b0) begin errors++; $display("[TB] FAIL flush_capture_squash got %0b want 0", squash); end
        checks++; if (redirect_v !== 1'b0) begin errors++; $display("[TB] FAIL flush_capture_redirect got %0b want 0", redirect_v); end
        checks++; if (attaboy_v !== 1'b0) begin errors++; $display("[TB] FAIL flush_capture_attaboy got %0b want 0", attaboy_v); end
        next_cycle();
        drive_branch(0, 'hA000, 'hA100, 'hA004, 0);
        next_cycle();
        clear_inputs();
        flush = 1;
        @(negedge clk);
        checks++; if (squash !== 1'b0) begin errors++; $display("[TB] FAIL flush_resolve_squash got %0b want 0", squash); end
        next_cycle();
        flush = 0;
        @(negedge clk);
        checks++; if (redirect_v !== 1'b0) begin errors++; $display("[TB] FAIL flush_resolve_redirect got %0b want 0", redirect_v); end
        checks++; if (cnt !== CW'(exp_cnt)) begin errors++; $display("[TB] FAIL flush_cnt got %0d want %0d", cnt, exp_cnt); end
    endtask

    task automatic test_misalign();
        next_cycle();
        drive_branch(1, 'h3000, 'h3004, 'h3002, 1);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (misalign_v !== 1'b1) begin errors++; $display("[TB] FAIL misalign_v got %0b want 1", misalign_v); end
        checks++; if (misalign_pc !== 39'h3002) begin errors++; $display("[TB] FAIL misalign_pc got %0h want 3002", misalign_pc); end
        checks++; if (squash !== 1'b0) begin errors++; $display("[TB] FAIL misalign_squash got %0b want 0", squash); end
        checks++; if (redirect_v !== 1'b0) begin errors++; $display("[TB] FAIL misalign_redirect got %0b want 0", redirect_v); end
        checks++; if (attaboy_v !== 1'b0) begin errors++; $display("[TB] FAIL misalign_attaboy got %0b want 0", attaboy_v); end
        next_cycle();
        @(negedge clk);
        checks++; if (misalign_v !== 1'b0) begin errors++; $display("[TB] FAIL misalign_pulse got %0b want 0", misalign_v); end
        checks++; if (cnt !== CW'(exp_cnt)) begin errors++; $display("[TB] FAIL misalign_cnt got %0d want %0d", cnt, exp_cnt); end
    endtask

    task automatic test_saturation_reset();
        ready = 1;
        for (int i = 0; i <= CNT_MAX; i++) begin
            next_cycle();
            drive_branch(0, 'hC000, 'hC100, 'hC004, 0);
            next_cycle();
            clear_inputs();
            @(negedge clk);
            checks++; if (redirect_v !== 1'b1) begin errors++; $display("[TB] FAIL sat_redirect_same_cycle got %0b want 1", redirect_v); end
            if (exp_cnt < CNT_MAX) exp_cnt++;
            next_cycle();
            @(negedge clk);
            checks++; if (redirect_v !== 1'b0) begin errors++; $display("[TB] FAIL sat_redirect_one_cycle got %0b want 0", redirect_v); end
            checks++; if (cnt !== CW'(exp_cnt)) begin errors++; $display("[TB] FAIL sat_cnt got %0d want %0d", cnt, exp_cnt); end
        end
        checks++; if (cnt !== CW'(CNT_MAX)) begin errors++; $display("[TB] FAIL sat_cnt_max got %0d want %0d", cnt, CNT_MAX); end
        ready = 0;
        next_cycle();
        drive_branch(0, 'hD000, 'hD100, 'hD004, 0);
        next_cycle();
        clear_inputs();
        next_cycle();
        @(negedge clk);
        checks++; if (redirect_v !== 1'b1) begin errors++; $display("[TB] FAIL rst_pend_before got %0b want 1", redirect_v); end
        #2;
        reset = 1;
        #1;
        checks++; if (redirect_v !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_redirect got %0b want 0", redirect_v); end
        checks++; if (cnt !== '0) begin errors++; $display("[TB] FAIL rst_async_cnt got %0d want 0", cnt); end
        exp_cnt = 0;
        next_cycle();
        reset = 0;
    endtask

    // Transaction model. The in-flight entry resolves one cycle after it is
    // taken. A mispredict opens a redirect that lives until it is accepted or
    // flushed. Nothing new is taken while that redirect is open.
    task automatic test_random();
        logic          m_v, m_taken, m_pend;
        logic [VW-1:0] m_pc, m_pred, m_tgt, m_pend_pc;
        int            m_cnt;
        logic          res, mis, good, bad, e_rv;
        logic [63:0]   r;
        reset = 1;
        #1;
        reset = 0;
        clear_inputs();
        ready = 0;
        m_v = 0; m_taken = 0; m_pend = 0; m_cnt = 0;
        m_pc = '0; m_pred = '0; m_tgt = '0; m_pend_pc = '0;
        for (int n = 0; n < 400; n++) begin
            next_cycle();
            v = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 4))
                0:       begin br_v = 0; jmp_v = 0; end
                1, 2:    begin br_v = 1; jmp_v = 0; end
                default: begin br_v = 0; jmp_v = 1; end
            endcase
            r = {$urandom(), $urandom()};
            pc = r[VW-1:0] & ~39'h3;
            taken = $urandom_range(0, 1);
            if (taken) begin
                br_tgt = pc + VW'({$urandom_range(0, 255), 2'b00});
                if ($urandom_range(0, 7) == 0) br_tgt = br_tgt + VW'(2);
            end else begin
                br_tgt = pc + VW'(4);
            end
            npc_pred = ($urandom_range(0, 1) == 1) ? br_tgt : (pc + VW'({$urandom_range(0, 255), 2'b00}));
            flush = ($urandom_range(0, 9) == 0);
            ready = $urandom_range(0, 1);
            @(negedge clk);
            res  = m_v && !flush;
            mis  = res && m_taken && (m_tgt % 4 != 0);
            good = res && !mis && (m_tgt == m_pred);
            bad  = res && !mis && (m_tgt != m_pred);
            e_rv = (m_pend || bad) && !flush;
            checks++; if (squash !== bad) begin errors++; $display("[TB] FAIL rnd_squash cyc %0d got %0b want %0b", n, squash, bad); end
            checks++; if (redirect_v !== e_rv) begin errors++; $display("[TB] FAIL rnd_redirect_v cyc %0d got %0b want %0b", n, redirect_v, e_rv); end
            if (e_rv) begin
                checks++; if (redirect_pc !== (bad ? m_tgt : m_pend_pc)) begin errors++; $display("[TB] FAIL rnd_redirect_pc cyc %0d got %0h want %0h", n, redirect_pc, bad ? m_tgt : m_pend_pc); end
            end
            checks++; if (attaboy_v !== good) begin errors++; $display("[TB] FAIL rnd_attaboy_v cyc %0d got %0b want %0b", n, attaboy_v, good); end
            if (good) begin
                checks++; if (attaboy_pc !== m_pc) begin errors++; $display("[TB] FAIL rnd_attaboy_pc cyc %0d got %0h want %0h", n, attaboy_pc, m_pc); end
            end
            checks++; if (misalign_v !== mis) begin errors++; $display("[TB] FAIL rnd_misalign_v cyc %0d got %0b want %0b", n, misalign_v, mis); end
            if (mis) begin
                checks++; if (misalign_pc !== m_tgt) begin errors++; $display("[TB] FAIL rnd_misalign_pc cyc %0d got %0h want %0h", n, misalign_pc, m_tgt); end
            end
            checks++; if (cnt !== CW'(m_cnt)) begin errors++; $display("[TB] FAIL rnd_cnt cyc %0d got %0d want %0d", n, cnt, m_cnt); end
            if (bad && m_cnt < CNT_MAX) m_cnt++;
            if (bad) m_pend_pc = m_tgt;
            m_v     = v && (br_v || jmp_v) && !flush && !(m_pend || bad);
            m_pend  = !flush && (m_pend || bad) && !(e_rv && ready);
            m_pc    = pc;
            m_pred  = npc_pred;
            m_tgt   = br_tgt;
            m_taken = taken;
        end
        clear_inputs();
        ready = 0;
    endtask

    initial begin
        reset = 1;
        ready = 0;
        exp_cnt = 0;
        clear_inputs();
        test_reset();
        test_correct_branch();
        test_mispredict_hold();
        test_back_to_back();
        test_flush();
        test_misalign();
        test_saturation_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_be_br_resolver.md
Name: bp_be_br_resolver

Overview:
- Sits directly downstream of the integer pipe in the calculator.
- Consumes the integer pipe's taken flag and branch target for each branch/jump, compares the actual next PC against the predicted next PC carried with the instruction, and issues a held redirect to the frontend on a mispredict.
- Also produces a one-cycle squash for younger instructions, an attaboy pulse on correct predictions, a misaligned-target exception pulse, and a saturating mispredict counter.

Parameters:
- vaddr_width_p, 39, virtual address width of PCs and targets.
- cnt_width_p, 32, width of the saturating mispredict counter.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset.
- v_i  in  1  instruction valid in the integer pipe this cycle.
- br_v_i  in  1  instruction is a conditional branch.
- jmp_v_i  in  1  instruction is jal/jalr.
- pc_i  in  vaddr_width_p  instruction PC.
- npc_pred_i  in  vaddr_width_p  predicted next PC from the frontend.
- taken_i  in  1  taken flag from the integer pipe.
- br_tgt_i  in  vaddr_width_p  integer pipe target: the target when taken, pc+4 otherwise.
- flush_i  in  1  exception/interrupt flush from the commit stage.
- redirect_ready_i  in  1  frontend command queue can accept a redirect.
- redirect_v_o  out  1  redirect valid (held until accepted).
- redirect_pc_o  out  vaddr_width_p  redirect target.
- squash_o  out  1  one-cycle kill of younger in-flight instructions.
- attaboy_v_o  out  1  one-cycle correct-prediction pulse.
- attaboy_pc_o  out  vaddr_width_p  PC of the correctly predicted instruction.
- misalign_v_o  out  1  one-cycle instruction-address-misaligned pulse.
- misalign_pc_o  out  vaddr_width_p  faulting target.
- mispredict_cnt_o  out  cnt_width_p  saturating mispredict count.

Behaviour:
- Reset:
  - Single clock clk_i; reset_i is asynchronous, active-high.
  - Reset clears all state registers. All valid/pulse outputs are 0, mispredict_cnt_o is 0, PC outputs are 0, and the FSM is in IDLE.
  - Reset asserted mid-PEND drops the pending redirect immediately.
- Stage 0 (capture, cycle N):
  - When v_i & (br_v_i | jmp_v_i) & ~flush_i & ~block, register pc_i, npc_pred_i, br_tgt_i, taken_i and a valid bit.
  - block = (state==PEND) | squash_o. Instructions arriving while blocked are wrong-path and are ignored.
- Stage 1 (resolve, cycle N+1), using the registered valid:
  - actual_npc = registered br_tgt. The comparison is full-width equality against the registered npc_pred.
  - Misalign check: actual_npc[1:0] != 0 with taken. Pulse misalign_v_o with misalign_pc_o = actual_npc. No redirect, no attaboy, no squash, no counter change. The exception path owns recovery.
  - Correct (actual_npc == npc_pred): attaboy_v_o=1 and attaboy_pc_o = registered pc for one cycle.
  - Mispredict: squash_o=1 for exactly this cycle, load the redirect register with actual_npc, and enter PEND. mispredict_cnt_o increments and saturates at all-ones.
  - Resolve outputs are suppressed if flush_i is high in the resolve cycle.
- FSM:
  - IDLE -> PEND on mispredict.
  - PEND: redirect_v_o=1 and redirect_pc_o is stable.
  - PEND -> IDLE on redirect_v_o & redirect_ready_i; the accept cycle is the last cycle valid is high.
  - If accepted in the same cycle it was raised, valid stays high for one cycle only.
  - PEND -> IDLE on flush_i, which has priority over ready: no redirect is issued and the commit stage redirects instead.
- Simultaneous events:
  - flush_i in the capture cycle or the resolve cycle discards that instruction.
  - flush_i has priority over everything except reset.
- Latency:
  - Resolve outputs appear 1 cycle after capture.
  - redirect_v_o rises in the same cycle as squash_o.
- Arithmetic: no wrap logic is needed. Targets are taken as-is from the integer pipe, and no sign extension is done here.

Decomposition:
- Add a bp_be_br_resolve_s struct to bp_be_pkg holding pc, npc_pred, tgt, taken and v. Parameterize it with a width macro in the style of the existing `bp_be_*_width macros.
- Add a resolver state enum {e_idle, e_pend} to bp_be_pkg.
- The counter is a natural sub-module: bp_be_sat_counter, with parameter width_p, inputs clk_i, reset_i, incr_i, and output count_o.

Test Plan:
- Correct taken branch: pc=0x1000, npc_pred=0x1040, br_tgt=0x1040, taken=1 -> next cycle attaboy_v_o=1, attaboy_pc_o=0x1000, no squash, counter stays 0.
- Mispredicted not-taken branch: pc=0x2000, npc_pred=0x2100, br_tgt=0x2004 -> next cycle squash_o=1 (1 cycle), redirect_v_o=1 with pc 0x2004. Hold redirect_ready_i=0 for 3 cycles: valid and pc stay stable. Ready=1 -> valid drops the next cycle; counter=1.
- Back-to-back branches during PEND: a second mispredicting v_i in PEND is ignored; only one redirect is issued, counter=1.
- Flush while PEND: flush_i=1 with ready=0 -> redirect_v_o=0 next cycle and state IDLE. flush_i in the capture cycle -> no outputs.
- Misaligned jalr: br_tgt=0x3002, taken=1 -> misalign_v_o=1 with misalign_pc_o=0x3002; no redirect or squash.
- Saturation and async reset: preload the counter to all-ones, mispredict -> count stays all-ones. Assert reset_i between clock edges during PEND -> redirect_v_o drops immediately and count=0.
